// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D-cache main-memory arbiter.
// Owner and FSM encodings, bank-select bit positions, and read-latency default.
// Carries no logic of its own.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_I = 2'd1,
    ST_OWN_D = 2'd2
  } state_e;

  // Read-return tag: one per issue slot; writes push vld=0
  typedef struct packed {
    logic   vld;
    owner_e own;
  } rtag_t;

  localparam int BANK_LO    = 1;
  localparam int BANK_HI    = 2;
  localparam int RD_LAT_DEF = 2;

endpackage

// File: rtl/mem_rtag_pipe.sv
// Read-return tag shift register: routes memory read data to the issuing cache.
// Latency RD_LAT cycles from push to rvalid; no backpressure, one tag per cycle.
// Asynchronous reset discards all in-flight tags.
module mem_rtag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  rtag_t push,
  output logic  rvalid_i,
  output logic  rvalid_d
);

  rtag_t pipe [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= push;
      for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign rvalid_i = pipe[RD_LAT-1].vld && (pipe[RD_LAT-1].own == OWN_I);
  assign rvalid_d = pipe[RD_LAT-1].vld && (pipe[RD_LAT-1].own == OWN_D);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing banked main memory between I-cache and D-cache.
// Grant is combinational in the request cycle; read data returns RD_LAT cycles later.
// Losing or locked-out requester sees stall=1 and must hold its request until gnt.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              req_d,
  input  logic              wr_i,
  input  logic              wr_d,
  input  logic              lock_i,
  input  logic              lock_d,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] wdata_d,
  output logic              gnt_i,
  output logic              gnt_d,
  output logic              stall_i,
  output logic              stall_d,
  output logic              rvalid_i,
  output logic              rvalid_d,
  output logic [DATA_W-1:0] rdata,
  input  logic [3:0]        mem_busy,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e state_q, state_d;
  logic   last_d_q;
  owner_e win;
  logic   elig_i, elig_d;
  rtag_t  rtag;

  assign elig_i = req_i && !mem_busy[addr_i[BANK_HI:BANK_LO]];
  assign elig_d = req_d && !mem_busy[addr_d[BANK_HI:BANK_LO]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      last_d_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (win != OWN_NONE) last_d_q <= (win == OWN_D);
    end
  end

  always_comb begin
    win     = OWN_NONE;
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (elig_i && elig_d) win = last_d_q ? OWN_I : OWN_D;
        else if (elig_i)      win = OWN_I;
        else if (elig_d)      win = OWN_D;
        if (win == OWN_I && lock_i)      state_d = ST_OWN_I;
        else if (win == OWN_D && lock_d) state_d = ST_OWN_D;
      end
      // Owner keeps the memory until it presents lock=0, granted or not
      ST_OWN_I: begin
        if (elig_i) win = OWN_I;
        if (!lock_i) state_d = ST_IDLE;
      end
      ST_OWN_D: begin
        if (elig_d) win = OWN_D;
        if (!lock_d) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (win)
      OWN_I: begin
        mem_rd    = !wr_i;
        mem_wr    = wr_i;
        mem_addr  = addr_i;
        mem_wdata = wdata_i;
      end
      OWN_D: begin
        mem_rd    = !wr_d;
        mem_wr    = wr_d;
        mem_addr  = addr_d;
        mem_wdata = wdata_d;
      end
      default: ;
    endcase
  end

  assign gnt_i   = (win == OWN_I);
  assign gnt_d   = (win == OWN_D);
  assign stall_i = req_i && !gnt_i;
  assign stall_d = req_d && !gnt_d;
  assign rdata   = mem_rdata;

  assign rtag.vld = mem_rd;
  assign rtag.own = win;

  mem_rtag_pipe #(.RD_LAT(RD_LAT)) u_rtag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rtag),
    .rvalid_i (rvalid_i),
    .rvalid_d (rvalid_d)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scenario tasks plus a read-return scoreboard
// checked every cycle against rvalid_i/rvalid_d/rdata.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 0, req_d = 0, wr_i = 0, wr_d = 0, lock_i = 0, lock_d = 0;
  logic [15:0] addr_i = '0, addr_d = '0, wdata_i = '0, wdata_d = '0;
  logic        gnt_i, gnt_d, stall_i, stall_d, rvalid_i, rvalid_d;
  logic [15:0] rdata;
  logic [3:0]  mem_busy = 4'b0000;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .req_d(req_d), .wr_i(wr_i), .wr_d(wr_d),
    .lock_i(lock_i), .lock_d(lock_d), .addr_i(addr_i), .addr_d(addr_d),
    .wdata_i(wdata_i), .wdata_d(wdata_d),
    .gnt_i(gnt_i), .gnt_d(gnt_d), .stall_i(stall_i), .stall_d(stall_d),
    .rvalid_i(rvalid_i), .rvalid_d(rvalid_d), .rdata(rdata),
    .mem_busy(mem_busy), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nbad = 0;

  // Memory model: returns addr ^ A5C3 two cycles after a read strobe
  logic        m0_v = 0, m1_v = 0;
  logic [15:0] m0_a = '0, m1_a = '0;
  always @(posedge clk) begin
    m1_v <= m0_v; m1_a <= m0_a;
    m0_v <= mem_rd; m0_a <= mem_addr;
  end
  assign mem_rdata = m1_v ? (m1_a ^ 16'hA5C3) : 16'h0000;

  typedef struct {
    int          due;
    logic        is_d;
    logic [15:0] data;
  } sb_t;
  sb_t sb[$];

  always @(negedge clk) begin
    logic        exp_i, exp_d;
    logic [15:0] exp_data;
    sb_t         e;
    exp_i = 1'b0; exp_d = 1'b0; exp_data = '0;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      nchk++; nbad++;
      $display("FAIL sb_stale: entry due %0d still queued at cycle %0d", e.due, cyc);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      exp_i = !e.is_d; exp_d = e.is_d; exp_data = e.data;
    end
    nchk++;
    if ({rvalid_i, rvalid_d} !== {exp_i, exp_d}) begin
      nbad++;
      $display("FAIL rvalid cyc=%0d: got i=%b d=%b want i=%b d=%b",
               cyc, rvalid_i, rvalid_d, exp_i, exp_d);
    end
    if (exp_i || exp_d) begin
      nchk++;
      if (rdata !== exp_data) begin
        nbad++;
        $display("FAIL rdata cyc=%0d: got %h want %h", cyc, rdata, exp_data);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_i = 0; req_d = 0; wr_i = 0; wr_d = 0; lock_i = 0; lock_d = 0;
    mem_busy = 4'b0000;
  endtask

  task automatic sb_push(input logic is_d, input logic [15:0] a);
    sb_t e;
    e.due = cyc + 2; e.is_d = is_d; e.data = a ^ 16'hA5C3;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    next_cycle();
    rst_n = 1'b0;
    idle_inputs();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    next_cycle();
    @(negedge clk);
    nchk++;
    if ({gnt_i, gnt_d, mem_rd, mem_wr, rvalid_i, rvalid_d} !== 6'b0) begin
      nbad++;
      $display("FAIL reset_outputs: got %b want 000000",
               {gnt_i, gnt_d, mem_rd, mem_wr, rvalid_i, rvalid_d});
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    nchk++;
    if ({gnt_i, gnt_d, mem_rd, mem_wr, stall_i, stall_d} !== 6'b0) begin
      nbad++;
      $display("FAIL idle_outputs: got %b want 000000",
               {gnt_i, gnt_d, mem_rd, mem_wr, stall_i, stall_d});
    end
  endtask

  task automatic test_single_read();
    next_cycle();
    req_i = 1; wr_i = 0; addr_i = 16'h0010;
    @(negedge clk);
    nchk++;
    if ({gnt_i, gnt_d, mem_rd, mem_wr, stall_i} !== 5'b10100) begin
      nbad++;
      $display("FAIL single_gnt: got gi/gd/rd/wr/si=%b want 10100",
               {gnt_i, gnt_d, mem_rd, mem_wr, stall_i});
    end
    nchk++;
    if (mem_addr !== 16'h0010) begin
      nbad++;
      $display("FAIL single_addr: got %h want 0010", mem_addr);
    end
    sb_push(1'b0, 16'h0010);
    next_cycle();
    req_i = 0;
    repeat (3) next_cycle();
  endtask

  task automatic test_tie();
    logic [15:0] ai, ad;
    logic        exp_i;
    apply_reset();
    ai = 16'h0102; ad = 16'h0204;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cycle();
      req_i = 1; wr_i = 0; addr_i = ai;
      req_d = 1; wr_d = 0; addr_d = ad;
      @(negedge clk);
      exp_i = (k % 2 == 0);
      nchk++;
      if ({gnt_i, gnt_d, stall_i, stall_d} !== {exp_i, !exp_i, !exp_i, exp_i}) begin
        nbad++;
        $display("FAIL tie_gnt k=%0d: got gi/gd/si/sd=%b want %b", k,
                 {gnt_i, gnt_d, stall_i, stall_d}, {exp_i, !exp_i, !exp_i, exp_i});
      end
      nchk++;
      if (mem_addr !== (exp_i ? ai : ad)) begin
        nbad++;
        $display("FAIL tie_addr k=%0d: got %h want %h", k, mem_addr, exp_i ? ai : ad);
      end
      if (exp_i) begin
        sb_push(1'b0, ai); ai = ai + 16'h0008;
      end else begin
        sb_push(1'b1, ad); ad = ad + 16'h0008;
      end
    end
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();
  endtask

  task automatic test_bank_conflict();
    next_cycle();
    mem_busy = 4'b0001;
    req_i = 1; wr_i = 0; addr_i = 16'h0020;
    req_d = 1; wr_d = 0; addr_d = 16'h0044;
    @(negedge clk);
    nchk++;
    if ({gnt_i, gnt_d, stall_i} !== 3'b011) begin
      nbad++;
      $display("FAIL conflict_d: got gi/gd/si=%b want 011", {gnt_i, gnt_d, stall_i});
    end
    sb_push(1'b1, 16'h0044);
    next_cycle();
    req_d = 0;
    @(negedge clk);
    nchk++;
    if ({gnt_i, stall_i, mem_rd} !== 3'b010) begin
      nbad++;
      $display("FAIL conflict_hold: got gi/si/rd=%b want 010", {gnt_i, stall_i, mem_rd});
    end
    next_cycle();
    mem_busy = 4'b0000;
    @(negedge clk);
    nchk++;
    if ({gnt_i, stall_i, mem_addr} !== {2'b10, 16'h0020}) begin
      nbad++;
      $display("FAIL conflict_release: got gi=%b si=%b addr=%h want 1 0 0020",
               gnt_i, stall_i, mem_addr);
    end
    sb_push(1'b0, 16'h0020);
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();
  endtask

  task automatic test_lock();
    apply_reset();
    req_d = 1; wr_d = 1; addr_d = 16'h0108; wdata_d = 16'hBEEF; lock_d = 1;
    @(negedge clk);
    nchk++;
    if ({gnt_d, mem_wr, mem_rd, mem_addr, mem_wdata} !== {3'b110, 16'h0108, 16'hBEEF}) begin
      nbad++;
      $display("FAIL lock_write: got gd/wr/rd=%b addr=%h wdata=%h want 110 0108 beef",
               {gnt_d, mem_wr, mem_rd}, mem_addr, mem_wdata);
    end
    next_cycle();
    req_i = 1; wr_i = 0; addr_i = 16'h0030;
    wr_d = 0; addr_d = 16'h0200; lock_d = 0;
    @(negedge clk);
    nchk++;
    if ({gnt_i, gnt_d, stall_i, mem_rd} !== 4'b0111) begin
      nbad++;
      $display("FAIL lock_fill: got gi/gd/si/rd=%b want 0111", {gnt_i, gnt_d, stall_i, mem_rd});
    end
    sb_push(1'b1, 16'h0200);
    next_cycle();
    req_d = 0;
    @(negedge clk);
    nchk++;
    if ({gnt_i, stall_i, mem_addr} !== {2'b10, 16'h0030}) begin
      nbad++;
      $display("FAIL lock_release: got gi=%b si=%b addr=%h want 1 0 0030",
               gnt_i, stall_i, mem_addr);
    end
    sb_push(1'b0, 16'h0030);
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();
  endtask

  task automatic test_reset_mid();
    next_cycle();
    req_i = 1; wr_i = 0; addr_i = 16'h0010;
    @(negedge clk);
    nchk++;
    if (gnt_i !== 1'b1) begin
      nbad++;
      $display("FAIL rstmid_issue: got gnt_i=%b want 1", gnt_i);
    end
    next_cycle();
    req_i = 0;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    req_i = 1; wr_i = 0; addr_i = 16'h0012;
    req_d = 1; wr_d = 0; addr_d = 16'h0024;
    @(negedge clk);
    nchk++;
    if ({gnt_i, gnt_d, stall_d} !== 3'b101) begin
      nbad++;
      $display("FAIL rstmid_tie: got gi/gd/sd=%b want 101", {gnt_i, gnt_d, stall_d});
    end
    sb_push(1'b0, 16'h0012);
    next_cycle();
    req_i = 0;
    @(negedge clk);
    nchk++;
    if (gnt_d !== 1'b1) begin
      nbad++;
      $display("FAIL rstmid_d: got gnt_d=%b want 1", gnt_d);
    end
    sb_push(1'b1, 16'h0024);
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_bank_conflict();
    test_lock();
    test_reset_mid();
    nchk++;
    if (sb.size() != 0) begin
      nbad++;
      $display("FAIL sb_drain: got %0d entries left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
